// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared definitions for the multiply-unit controller: FSM encoding and default width.
package mdu_hilo_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// EX-stage and serialmult-facing signals of the HI/LO controller.
// master = environment (EX stage + serialmult), slave = controller.
interface mdu_hilo_ctrl_if
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic              ex_mult;
  logic              ex_signed;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic              ex_mfhi;
  logic              ex_mflo;
  logic              ex_mthi;
  logic              ex_mtlo;
  logic [XLEN-1:0]   ex_wdata;
  logic [XLEN-1:0]   rdata;
  logic              stall;
  logic              busy;
  logic              mst;
  logic              msgn;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] prod;
  logic              prodv;

  modport master (
    output ex_mult, ex_signed, ex_a, ex_b, ex_mfhi, ex_mflo, ex_mthi, ex_mtlo, ex_wdata,
    output prod, prodv,
    input  rdata, stall, busy, mst, msgn, ma, mb
  );

  modport slave (
    input  ex_mult, ex_signed, ex_a, ex_b, ex_mfhi, ex_mflo, ex_mthi, ex_mtlo, ex_wdata,
    input  prod, prodv,
    output rdata, stall, busy, mst, msgn, ma, mb
  );

endinterface

// File: rtl/mdu_hilo_ctrl_hilo_regs.sv
// HI/LO register pair with independent write enables and a read mux that can
// forward the incoming product in the cycle it is written.
module mdu_hilo_ctrl_hilo_regs #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [XLEN-1:0]   hi_wdata,
  input  logic [XLEN-1:0]   lo_wdata,
  input  logic              rd_hi,
  input  logic              rd_lo,
  input  logic              byp,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_hi) begin
      rdata = byp ? prod[2*XLEN-1:XLEN] : hi_q;
    end else if (rd_lo) begin
      rdata = byp ? prod[XLEN-1:0] : lo_q;
    end
  end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Multiply controller: launches serialmult with held operands, waits for the
// product, writes HI/LO, and stalls EX on HI/LO or multiply hazards.
module mdu_hilo_ctrl
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mdu_hilo_ctrl_if.slave bus
);

  mdu_state_e      state_q, state_d;
  logic            mst_q;
  logic            msgn_q;
  logic [XLEN-1:0] ma_q;
  logic [XLEN-1:0] mb_q;

  logic            accept;
  logic            wr_req;
  logic            any_req;
  logic            busy_prodv;
  logic            stall;
  logic            rd_hi;
  logic            rd_lo;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] hi_wdata;
  logic [XLEN-1:0] lo_wdata;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    stall      = 1'b0;
    wr_req     = bus.ex_mult | bus.ex_mthi | bus.ex_mtlo;
    any_req    = wr_req | bus.ex_mfhi | bus.ex_mflo;
    busy_prodv = (state_q == StBusy) & bus.prodv;
    // Reads lose to any simultaneous write-type request.
    rd_hi      = bus.ex_mfhi & ~wr_req;
    rd_lo      = bus.ex_mflo & ~wr_req & ~bus.ex_mfhi;

    unique case (state_q)
      StIdle: begin
        if (bus.ex_mult) begin
          accept  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        stall   = any_req;
        state_d = StBusy;
      end
      StBusy: begin
        // Reads are served via the product bypass on the completion cycle.
        stall = busy_prodv ? wr_req : any_req;
        if (bus.prodv) state_d = StIdle;
      end
      default: begin
        stall   = any_req;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    hi_we    = busy_prodv |
               ((state_q == StIdle) & ~bus.ex_mult & bus.ex_mthi);
    lo_we    = busy_prodv |
               ((state_q == StIdle) & ~bus.ex_mult & ~bus.ex_mthi & bus.ex_mtlo);
    hi_wdata = busy_prodv ? bus.prod[2*XLEN-1:XLEN] : bus.ex_wdata;
    lo_wdata = busy_prodv ? bus.prod[XLEN-1:0] : bus.ex_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mst_q   <= 1'b0;
      msgn_q  <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      mst_q   <= accept;
      if (accept) begin
        msgn_q <= bus.ex_signed;
        ma_q   <= bus.ex_a;
        mb_q   <= bus.ex_b;
      end
    end
  end

  mdu_hilo_ctrl_hilo_regs #(
    .XLEN(XLEN)
  ) u_hilo_regs (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .byp      (busy_prodv),
    .prod     (bus.prod),
    .rdata    (bus.rdata)
  );

  assign bus.stall = stall;
  assign bus.busy  = (state_q != StIdle);
  assign bus.mst   = mst_q;
  assign bus.msgn  = msgn_q;
  assign bus.ma    = ma_q;
  assign bus.mb    = mb_q;

endmodule
